// File: rtl/data_mem_arb_pkg.sv
// data_mem_arb_pkg
// Shared types and constants for the two-port data memory arbiter:
//   arb_state_t   - arbiter FSM states (IDLE / ACCESS / RESP)
//   PORT0/PORT1   - requester index constants
//   MEM_WORDS_DEF - default data memory size in 32-bit words
//   mem_req_t     - latched access (we, byte address, write data)
package data_mem_arb_pkg;

  localparam int   MEM_WORDS_DEF = 1024;
  localparam logic PORT0         = 1'b0;
  localparam logic PORT1         = 1'b1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } arb_state_t;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } mem_req_t;

endpackage

// File: rtl/rr_pick2.sv
// rr_pick2
// Two-way round-robin pick. A lone requester always wins; when both request,
// the port that was not granted most recently wins.
//   i_req  [1:0] - request vector (bit n = port n)
//   i_last       - index of the port granted most recently
//   o_gnt  [1:0] - one-hot grant (all zero when nothing requests)
module rr_pick2 (
  input  logic [1:0] i_req,
  input  logic       i_last,
  output logic [1:0] o_gnt
);

  always_comb begin
    o_gnt = i_req;
    if (i_req == 2'b11) o_gnt = i_last ? 2'b01 : 2'b10;
  end

endmodule

// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter
// Arbitrates two requesters onto one single-port data memory. Each access
// takes three cycles: IDLE (arbitrate + latch), ACCESS (drive memory,
// capture read data), RESP (one-cycle ack/err to the winner).
//   clk, rst                  - clock, synchronous active-high reset
//   req/we/addr/wdata{0,1}    - requester inputs, req held until ack
//   ack/err/rdata{0,1}        - completion pulse, reject flag, read data
//   memWrite/memAddr/memWriteData - memory strobe, address, write data
//   memReadData               - combinational memory read data
module data_mem_arbiter
  import data_mem_arb_pkg::*;
#(
  parameter int MEM_WORDS = MEM_WORDS_DEF,
  parameter int NUM_REQ   = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0,
  input  logic        req1,
  input  logic        we0,
  input  logic        we1,
  input  logic [31:0] addr0,
  input  logic [31:0] addr1,
  input  logic [31:0] wdata0,
  input  logic [31:0] wdata1,
  output logic        ack0,
  output logic        ack1,
  output logic        err0,
  output logic        err1,
  output logic [31:0] rdata0,
  output logic [31:0] rdata1,
  output logic        memWrite,
  output logic [31:0] memAddr,
  output logic [31:0] memWriteData,
  input  logic [31:0] memReadData
);

  arb_state_t         r_state, w_next;
  mem_req_t           r_req, w_sel;
  logic               r_port;   // port that owns the in-flight access
  logic               r_last;   // round-robin pointer: last granted port
  logic               r_err;
  logic [31:0]        r_rdata0, r_rdata1;
  logic [NUM_REQ-1:0] w_req, w_gnt;
  logic               w_legal;
  logic [31:0]        w_rdata;

  assign w_req = {req1, req0};

  rr_pick2 u_pick (
    .i_req  (w_req),
    .i_last (r_last),
    .o_gnt  (w_gnt)
  );

  assign w_sel = w_gnt[1] ? {we1, addr1, wdata1} : {we0, addr0, wdata0};

  // Word aligned and inside the memory; anything else is rejected with err.
  assign w_legal = (r_req.addr[1:0] == 2'b00) &&
                   ({2'b00, r_req.addr[31:2]} < 32'(MEM_WORDS));

  // Writes and rejected accesses return zero rather than memory contents.
  assign w_rdata = (r_req.we || !w_legal) ? 32'h0 : memReadData;

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next       = r_state;
    memWrite     = 1'b0;
    memAddr      = 32'h0;
    memWriteData = 32'h0;
    ack0         = 1'b0;
    ack1         = 1'b0;
    err0         = 1'b0;
    err1         = 1'b0;
    case (r_state)
      IDLE:   if (|w_req) w_next = ACCESS;
      ACCESS: begin
        memAddr      = r_req.addr;
        memWriteData = r_req.wdata;
        // rst gates the strobe combinationally so an aborted write never lands
        memWrite     = r_req.we && w_legal && !rst;
        w_next       = RESP;
      end
      RESP: begin
        ack0   = (r_port == PORT0);
        ack1   = (r_port == PORT1);
        err0   = (r_port == PORT0) && r_err;
        err1   = (r_port == PORT1) && r_err;
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_req    <= '0;
      r_port   <= PORT0;
      r_last   <= PORT1;   // port 0 wins the first contested grant
      r_err    <= 1'b0;
      r_rdata0 <= 32'h0;
      r_rdata1 <= 32'h0;
    end else begin
      if (r_state == IDLE && |w_req) begin
        r_req  <= w_sel;
        r_port <= w_gnt[1];
        r_last <= w_gnt[1];
      end
      if (r_state == ACCESS) begin
        r_err <= !w_legal;
        if (r_port == PORT0) r_rdata0 <= w_rdata;
        else                 r_rdata1 <= w_rdata;
      end
    end
  end

  assign rdata0 = r_rdata0;
  assign rdata1 = r_rdata1;

endmodule
